// File: rtl/cdb_arbiter_if.sv
// Bundle of the CDB arbiter's request and broadcast signals.
// Latency: none; this is wiring only.
// Backpressure: a requester holds its fields while req_valid is high and req_ready is low.
//
// Modports:
//   master : execution-unit side. Drives flush, req_valid and the req_* fields.
//            Sees req_ready, cdb_* and grant_cnt.
//   slave  : arbiter side. The signal directions are the reverse of master.
interface cdb_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 6
);
  logic                      flush;
  logic [N_REQ-1:0]          req_valid;
  logic [N_REQ*DATA_W-1:0]   req_data;
  logic [N_REQ*TAG_W-1:0]    req_tag;
  logic [N_REQ-1:0]          req_branch;
  logic [N_REQ-1:0]          req_branch_taken;
  logic [N_REQ-1:0]          req_store_pc;
  logic [N_REQ-1:0]          req_jalr;
  logic [N_REQ-1:0]          req_ready;
  logic [DATA_W-1:0]         cdb_data;
  logic [TAG_W-1:0]          cdb_tag;
  logic                      cdb_valid;
  logic                      cdb_branch;
  logic                      cdb_branch_taken;
  logic                      cdb_store_pc;
  logic                      cdb_jalr;
  logic [15:0]               grant_cnt;

  modport master (
    output flush, req_valid, req_data, req_tag, req_branch, req_branch_taken,
           req_store_pc, req_jalr,
    input  req_ready, cdb_data, cdb_tag, cdb_valid, cdb_branch, cdb_branch_taken,
           cdb_store_pc, cdb_jalr, grant_cnt
  );

  modport slave (
    input  flush, req_valid, req_data, req_tag, req_branch, req_branch_taken,
           req_store_pc, req_jalr,
    output req_ready, cdb_data, cdb_tag, cdb_valid, cdb_branch, cdb_branch_taken,
           cdb_store_pc, cdb_jalr, grant_cnt
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter. It picks one finished execution-unit result per cycle and broadcasts it.
// Latency: the grant (req_ready) is combinational. The broadcast is registered onto cdb_* one edge later.
// Backpressure: losing requesters see req_ready=0, hold their result and retry. Flush blocks every grant.
//
// Ports:
//   clk  : rising-edge clock.
//   rst  : asynchronous, active-high reset.
//   bus  : slave modport of cdb_arbiter_if. It carries the request fields, the one-hot
//          req_ready grant, the registered cdb_* broadcast and grant_cnt.
//
// Build option CDB_ARB_RR_EN:
//   When defined, the arbiter uses round-robin from a pointer. The pointer holds the index after the last winner.
//   When undefined, the arbiter uses fixed priority: index 0 (ALU) wins.
module cdb_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 6
) (
  input  logic            clk,
  input  logic            rst,
  cdb_arbiter_if.slave    bus
);

  logic [N_REQ-1:0]  gnt;
  logic              any_gnt;
  logic [DATA_W-1:0] sel_data;
  logic [TAG_W-1:0]  sel_tag;
  logic              sel_branch;
  logic              sel_taken;
  logic              sel_store_pc;
  logic              sel_jalr;

  logic              cdb_valid_q,  cdb_valid_d;
  logic [DATA_W-1:0] cdb_data_q,   cdb_data_d;
  logic [TAG_W-1:0]  cdb_tag_q,    cdb_tag_d;
  logic              cdb_branch_q, cdb_branch_d;
  logic              cdb_taken_q,  cdb_taken_d;
  logic              cdb_spc_q,    cdb_spc_d;
  logic              cdb_jalr_q,   cdb_jalr_d;
  logic [15:0]       grant_cnt_q,  grant_cnt_d;

`ifdef CDB_ARB_RR_EN
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]  win_idx;
  logic [PTR_W-1:0]  scan_idx;
`endif

  // Grant selection. Reset and flush both hold req_ready low, so no
  // requester can believe it handed off a result that will never be broadcast.
  always_comb begin
    gnt     = '0;
    any_gnt = 1'b0;
`ifdef CDB_ARB_RR_EN
    win_idx  = '0;
    scan_idx = '0;
    if (!rst && !bus.flush) begin
      for (int k = 0; k < N_REQ; k++) begin
        scan_idx = PTR_W'((int'(rr_ptr_q) + k) % N_REQ);
        if (!any_gnt && bus.req_valid[scan_idx]) begin
          gnt[scan_idx] = 1'b1;
          any_gnt       = 1'b1;
          win_idx       = scan_idx;
        end
      end
    end
`else
    if (!rst && !bus.flush) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!any_gnt && bus.req_valid[i]) begin
          gnt[i]  = 1'b1;
          any_gnt = 1'b1;
        end
      end
    end
`endif
  end

  // One-hot mux of the winning requester's fields.
  always_comb begin
    sel_data     = '0;
    sel_tag      = '0;
    sel_branch   = 1'b0;
    sel_taken    = 1'b0;
    sel_store_pc = 1'b0;
    sel_jalr     = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        sel_data     = bus.req_data[i*DATA_W +: DATA_W];
        sel_tag      = bus.req_tag[i*TAG_W +: TAG_W];
        sel_branch   = bus.req_branch[i];
        sel_taken    = bus.req_branch_taken[i];
        sel_store_pc = bus.req_store_pc[i];
        sel_jalr     = bus.req_jalr[i];
      end
    end
  end

  // Broadcast register next state. Payload fields hold through idle cycles.
  // Only cdb_valid drops.
  always_comb begin
    cdb_valid_d  = any_gnt;
    cdb_data_d   = cdb_data_q;
    cdb_tag_d    = cdb_tag_q;
    cdb_branch_d = cdb_branch_q;
    cdb_taken_d  = cdb_taken_q;
    cdb_spc_d    = cdb_spc_q;
    cdb_jalr_d   = cdb_jalr_q;
    grant_cnt_d  = grant_cnt_q;
    if (any_gnt) begin
      cdb_data_d   = sel_data;
      cdb_tag_d    = sel_tag;
      cdb_branch_d = sel_branch;
      cdb_taken_d  = sel_taken;
      cdb_spc_d    = sel_store_pc;
      cdb_jalr_d   = sel_jalr;
      grant_cnt_d  = grant_cnt_q + 16'd1;   // wraps 16'hFFFF -> 0
    end
  end

`ifdef CDB_ARB_RR_EN
  // The pointer moves past the winner only on a granted cycle.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (any_gnt) begin
      if (win_idx == PTR_W'(N_REQ - 1)) rr_ptr_d = '0;
      else                              rr_ptr_d = win_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cdb_valid_q  <= 1'b0;
      cdb_data_q   <= '0;
      cdb_tag_q    <= '0;
      cdb_branch_q <= 1'b0;
      cdb_taken_q  <= 1'b0;
      cdb_spc_q    <= 1'b0;
      cdb_jalr_q   <= 1'b0;
      grant_cnt_q  <= '0;
    end else begin
      cdb_valid_q  <= cdb_valid_d;
      cdb_data_q   <= cdb_data_d;
      cdb_tag_q    <= cdb_tag_d;
      cdb_branch_q <= cdb_branch_d;
      cdb_taken_q  <= cdb_taken_d;
      cdb_spc_q    <= cdb_spc_d;
      cdb_jalr_q   <= cdb_jalr_d;
      grant_cnt_q  <= grant_cnt_d;
    end
  end

  assign bus.req_ready        = gnt;
  assign bus.cdb_valid        = cdb_valid_q;
  assign bus.cdb_data         = cdb_data_q;
  assign bus.cdb_tag          = cdb_tag_q;
  assign bus.cdb_branch       = cdb_branch_q;
  assign bus.cdb_branch_taken = cdb_taken_q;
  assign bus.cdb_store_pc     = cdb_spc_q;
  assign bus.cdb_jalr         = cdb_jalr_q;
  assign bus.grant_cnt        = grant_cnt_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter. The stimulus drives directed vectors and queues the expected broadcasts.
// A monitor pops one queued broadcast each time cdb_valid is high and compares it with the bus.
module tb_cdb_arbiter;

  logic clk;
  logic rst;

  cdb_arbiter_if #(.N_REQ(4), .DATA_W(32), .TAG_W(6)) bus ();

  cdb_arbiter #(.N_REQ(4), .DATA_W(32), .TAG_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [5:0]  tag;
    logic        br;
    logic        tk;
    logic        sp;
    logic        jr;
    logic [15:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  int          n_chk  = 0;
  int          n_pass = 0;
  logic [15:0] exp_cnt = '0;

  logic [31:0] f_data [4];
  logic [5:0]  f_tag  [4];
  logic        f_br   [4];
  logic        f_tk   [4];
  logic        f_sp   [4];
  logic        f_jr   [4];

  always_comb begin
    bus.req_data         = '0;
    bus.req_tag          = '0;
    bus.req_branch       = '0;
    bus.req_branch_taken = '0;
    bus.req_store_pc     = '0;
    bus.req_jalr         = '0;
    for (int i = 0; i < 4; i++) begin
      bus.req_data[i*32 +: 32]   = f_data[i];
      bus.req_tag[i*6 +: 6]      = f_tag[i];
      bus.req_branch[i]          = f_br[i];
      bus.req_branch_taken[i]    = f_tk[i];
      bus.req_store_pc[i]        = f_sp[i];
      bus.req_jalr[i]            = f_jr[i];
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic set_req(input int i, input logic [31:0] d, input logic [5:0] t,
                         input logic br, input logic tk, input logic sp, input logic jr);
    f_data[i] = d; f_tag[i] = t; f_br[i] = br; f_tk[i] = tk; f_sp[i] = sp; f_jr[i] = jr;
  endtask

  // The task is called at posedge+2. It drives one cycle, checks the grant,
  // queues the expected broadcast and returns at the next posedge+2.
  task automatic cycle(input logic [3:0] v, input logic fl, input logic [3:0] exp_rdy,
                       input string nm);
    exp_t e;
    bus.req_valid = v;
    bus.flush     = fl;
    #1;
    check({nm, "_rdy"}, 64'(bus.req_ready), 64'(exp_rdy));
    for (int i = 0; i < 4; i++) begin
      if (exp_rdy[i]) begin
        exp_cnt = exp_cnt + 16'd1;
        e = '{data: f_data[i], tag: f_tag[i], br: f_br[i], tk: f_tk[i],
              sp: f_sp[i], jr: f_jr[i], cnt: exp_cnt};
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #2;
  endtask

  // Monitor: every broadcast must match the oldest expected entry.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (bus.cdb_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("cdb_unexpected_valid", 64'(bus.cdb_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("cdb_data",  64'(bus.cdb_data), 64'(e.data));
        check("cdb_tag",   64'(bus.cdb_tag),  64'(e.tag));
        check("cdb_flags", 64'({bus.cdb_branch, bus.cdb_branch_taken, bus.cdb_store_pc, bus.cdb_jalr}),
                           64'({e.br, e.tk, e.sp, e.jr}));
        check("grant_cnt", 64'(bus.grant_cnt), 64'(e.cnt));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4; i++) set_req(i, 32'h0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst           = 1'b1;
    bus.flush     = 1'b0;
    bus.req_valid = 4'b1111;
    #3;
    check("rst_rdy",   64'(bus.req_ready), 64'd0);
    check("rst_valid", 64'(bus.cdb_valid), 64'd0);
    check("rst_cnt",   64'(bus.grant_cnt), 64'd0);
    repeat (2) @(posedge clk);
    #2;
    rst           = 1'b0;
    bus.req_valid = 4'b0000;

    // A single multiplier result.
    set_req(2, 32'h3C, 6'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(4'b0100, 1'b0, 4'b0100, "single_mul");
    check("single_cdb_valid", 64'(bus.cdb_valid), 64'd1);
    cycle(4'b0000, 1'b0, 4'b0000, "idle0");
    check("idle_cdb_valid", 64'(bus.cdb_valid), 64'd0);

    // Flush blocks the grant. Once it is released, the ALU wins, then the load unit.
    set_req(0, 32'hA0A0_0001, 6'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    set_req(1, 32'hB1B1_0002, 6'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(4'b0011, 1'b1, 4'b0000, "flush");
    check("flush_cdb_valid", 64'(bus.cdb_valid), 64'd0);
    cycle(4'b0011, 1'b0, 4'b0001, "unflush");
    cycle(4'b0010, 1'b0, 4'b0010, "after_flush");
    cycle(4'b0000, 1'b0, 4'b0000, "idle1");

    // Branch flags from the ALU, then a JALR link PC from the divider slot.
    set_req(0, 32'h0000_1234, 6'd17, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(4'b0001, 1'b0, 4'b0001, "branch");
    set_req(3, 32'h8000_0040, 6'd33, 1'b0, 1'b0, 1'b1, 1'b1);
    cycle(4'b1000, 1'b0, 4'b1000, "jalr");
    cycle(4'b0000, 1'b0, 4'b0000, "idle2");

    // All four requesters contend. Each one drops after it is granted.
    for (int i = 0; i < 4; i++)
      set_req(i, 32'hC000_0000 + 32'(i), 6'(10 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(4'b1111, 1'b0, 4'b0001, "cont0");
    cycle(4'b1110, 1'b0, 4'b0010, "cont1");
    cycle(4'b1100, 1'b0, 4'b0100, "cont2");
    cycle(4'b1000, 1'b0, 4'b1000, "cont3");
    cycle(4'b0000, 1'b0, 4'b0000, "idle3");

    // Requesters 0 and 3 are both held valid continuously.
`ifdef CDB_ARB_RR_EN
    cycle(4'b1001, 1'b0, 4'b0001, "hold0");
    cycle(4'b1001, 1'b0, 4'b1000, "hold1");
    cycle(4'b1001, 1'b0, 4'b0001, "hold2");
    cycle(4'b1001, 1'b0, 4'b1000, "hold3");
`else
    cycle(4'b1001, 1'b0, 4'b0001, "hold0");
    cycle(4'b1001, 1'b0, 4'b0001, "hold1");
    cycle(4'b1001, 1'b0, 4'b0001, "hold2");
    cycle(4'b1001, 1'b0, 4'b0001, "hold3");
`endif
    cycle(4'b0000, 1'b0, 4'b0000, "idle4");

    // Reset is asserted mid-cycle while a broadcast is on the bus and all requests are pending.
    cycle(4'b1111, 1'b0, 4'b0001, "pre_rst");
    check("pre_rst_valid", 64'(bus.cdb_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_rdy",   64'(bus.req_ready), 64'd0);
    check("mid_rst_valid", 64'(bus.cdb_valid), 64'd0);
    check("mid_rst_cnt",   64'(bus.grant_cnt), 64'd0);
    check("mid_rst_data",  64'(bus.cdb_data),  64'd0);
    exp_cnt = '0;
    @(posedge clk);
    #2;
    check("rst_hold_valid", 64'(bus.cdb_valid), 64'd0);
    rst = 1'b0;

    // After reset the round-robin pointer is back at 0, so the ALU wins over the divider.
    cycle(4'b1001, 1'b0, 4'b0001, "post_rst");
    cycle(4'b0000, 1'b0, 4'b0000, "idle5");
    repeat (2) @(posedge clk);
    #2;
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
